batch_capture_scheduler: RTL and testbench
==========================================

Name: batch_capture_scheduler

Overview:
- Single-clock controller that sequences the ADC input buffer through a programmed number of capture runs of BATCH_SIZE samples each.
- Each run: issues a capture request, waits for the buffer to report fill, then polices the buffer's drained output stream (sop/eop/valid framing and sample count).
- Inserts a programmable idle gap between runs; reports done, error and progress.
- Sits on the source-clock side between the system control logic and the input buffer.

Parameters:
- BATCH_SIZE, 2048, samples per run; expected valid beats from sop to eop inclusive.
- MAX_RUNS, 8, largest legal cfg_runs value.
- GAP_WIDTH, 16, width of cfg_gap.
- TIMEOUT, 65536, cycles allowed in CAPTURE or in DRAIN before error.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a sequence when idle.
- abort  in  1  pulse; cancels the sequence from any state.
- cfg_runs  in  $clog2(MAX_RUNS+1)  run count; sampled on accepted start.
- cfg_gap  in  GAP_WIDTH  idle cycles between runs; sampled on accepted start.
- capture_req  out  1  one-cycle pulse telling the buffer to capture one batch.
- capture_ack  in  1  pulse from the buffer: batch written.
- src_valid  in  1  buffer output valid.
- src_sop  in  1  buffer start of packet; qualified by src_valid.
- src_eop  in  1  buffer end of packet; qualified by src_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all runs complete.
- err  out  1  sticky error flag.
- err_code  out  2  1 = timeout, 2 = framing, 3 = count mismatch.
- run_idx  out  $clog2(MAX_RUNS)  index of the current run (0-based).

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; capture_req=0, busy=0, done=0, err=0, err_code=0, run_idx=0; all counters=0.
- States: IDLE, ARM, CAPTURE, DRAIN, GAP, DONE.
- IDLE:
  - start=1 with 1 <= cfg_runs <= MAX_RUNS -> ARM; latch cfg_runs and cfg_gap; clear err, err_code, run_idx.
  - start with cfg_runs=0 or cfg_runs>MAX_RUNS is ignored.
- ARM: capture_req=1 for exactly this cycle -> CAPTURE; timeout counter cleared.
- CAPTURE: capture_ack=1 -> DRAIN; sample counter cleared.
- DRAIN: each src_valid beat is checked in order:
  - sop while in a frame -> framing error.
  - valid beat before the first sop -> framing error.
  - otherwise the beat increments the sample counter, width $clog2(BATCH_SIZE+1).
  - sop and eop in the same beat is a one-sample frame.
  - On an eop beat, the count including that beat must equal BATCH_SIZE, else count-mismatch error. A count reaching BATCH_SIZE without eop is also a mismatch on the next valid beat.
  - Good eop, run_idx == latched runs-1 -> DONE.
  - Good eop, otherwise -> run_idx+1 and GAP.
- GAP: count latched cfg_gap cycles, then -> ARM. cfg_gap=0 goes to ARM on the next cycle, so there is exactly one cycle between the eop beat and the next capture_req.
- DONE: done=1 for one cycle -> IDLE.
- Timeout: the counter runs in CAPTURE and DRAIN and resets on each state entry. Reaching TIMEOUT-1 -> error.
- Error: err=1 and err_code set (first error wins), then -> IDLE the next cycle. err stays high until the next accepted start.
- src_valid outside DRAIN is ignored (no error).
- capture_ack outside CAPTURE is ignored.
- abort in any state:
  - Next state is IDLE.
  - capture_req is forced low that cycle.
  - No done pulse; err is unchanged; run_idx holds its value.
  - abort and start in the same cycle: abort wins.
- done and err are never both set by the same sequence.
- Latency: start to capture_req = 1 cycle (ARM in the cycle after start, capture_req asserted during ARM).

Test Plan:
- cfg_runs=3, cfg_gap=10, BATCH_SIZE=2048, well-formed frames with ack 50 cycles after each req -> three capture_req pulses, run_idx 0,1,2, done pulse once, err=0, busy falls the cycle after done.
- cfg_gap=0, cfg_runs=2 -> second capture_req exactly 2 cycles after the first frame's eop beat.
- Frame with 2047 beats ending in eop -> err=1, err_code=3, return to IDLE, no done; a new start clears err.
- sop reasserted mid-frame at beat 100 -> err_code=2; a valid beat without a preceding sop -> err_code=2.
- capture_ack withheld with TIMEOUT=256 -> err_code=1 256 cycles after entering CAPTURE.
- abort during GAP of run 1, plus start with cfg_runs=0, plus reset_n pulsed low mid-DRAIN -> IDLE with no done; cfg_runs=0 start leaves busy=0; reset mid-DRAIN clears all outputs immediately (asynchronously).

Source files
------------

// File: rtl/batch_capture_scheduler.sv
// Capture-run sequencer for the ADC input buffer: arms N batch captures,
// polices each drained frame, inserts idle gaps and reports done/err.
module batch_capture_scheduler #(
    parameter  int BATCH_SIZE = 2048,
    parameter  int MAX_RUNS   = 8,
    parameter  int GAP_WIDTH  = 16,
    parameter  int TIMEOUT    = 65536,
    localparam int RUNS_W     = $clog2(MAX_RUNS + 1),
    localparam int IDX_W      = (MAX_RUNS > 1) ? $clog2(MAX_RUNS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RUNS_W-1:0]    cfg_runs,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    output logic                 capture_req,
    input  logic                 capture_ack,
    input  logic                 src_valid,
    input  logic                 src_sop,
    input  logic                 src_eop,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [IDX_W-1:0]     run_idx
);

    localparam int CNT_W = $clog2(BATCH_SIZE + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BATCH_SIZE);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] E_TMO = 2'd1;
    localparam logic [1:0] E_FRM = 2'd2;
    localparam logic [1:0] E_CNT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [RUNS_W-1:0]    runs_q, runs_d;
    logic [GAP_WIDTH-1:0] gcfg_q, gcfg_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [TO_W-1:0]      tmo_q, tmo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 frame_q, frame_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;

    logic                 fault;
    logic [1:0]           fcode;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 last_run;
    logic                 cfg_ok;

    assign cfg_ok   = (cfg_runs != '0) && (cfg_runs <= RUNS_W'(MAX_RUNS));
    assign last_run = (RUNS_W'(idx_q) == runs_q - RUNS_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            runs_q  <= '0;
            gcfg_q  <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            runs_q  <= runs_d;
            gcfg_q  <= gcfg_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        runs_d   = runs_q;
        gcfg_d   = gcfg_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        err_d    = err_q;
        code_d   = code_q;
        fault    = 1'b0;
        fcode    = 2'd0;
        beat_cnt = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start && cfg_ok) begin
                    state_d = S_ARM;
                    runs_d  = cfg_runs;
                    gcfg_d  = cfg_gap;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    idx_d   = '0;
                end
            end
            S_ARM: begin
                state_d = S_CAPTURE;
                tmo_d   = '0;
            end
            S_CAPTURE: begin
                if (capture_ack) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    frame_d = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_q == TO_LAST) begin
                    fault = 1'b1;
                    fcode = E_TMO;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            S_DRAIN: begin
                tmo_d = tmo_q + TO_W'(1);
                if (src_valid) begin
                    if (src_sop == frame_q) begin
                        // sop inside a frame, or data before any sop
                        fault = 1'b1;
                        fcode = E_FRM;
                    end else if (!src_sop && cnt_q == CNT_FULL) begin
                        fault = 1'b1;
                        fcode = E_CNT;
                    end else begin
                        beat_cnt = src_sop ? CNT_W'(1) : cnt_q + CNT_W'(1);
                        cnt_d    = beat_cnt;
                        frame_d  = !src_eop;
                        if (src_eop) begin
                            if (beat_cnt != CNT_FULL) begin
                                fault = 1'b1;
                                fcode = E_CNT;
                            end else if (last_run) begin
                                state_d = S_DONE;
                            end else begin
                                idx_d   = idx_q + IDX_W'(1);
                                gap_d   = gcfg_q;
                                state_d = S_GAP;
                            end
                        end
                    end
                end
                if (!fault && state_d == S_DRAIN && tmo_q == TO_LAST) begin
                    fault = 1'b1;
                    fcode = E_TMO;
                end
            end
            S_GAP: begin
                // a zero gap still spends one cycle here
                if (gap_q <= GAP_WIDTH'(1)) begin
                    state_d = S_ARM;
                end else begin
                    gap_d = gap_q - GAP_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fault) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = fcode;
        end

        if (abort) begin
            state_d = S_IDLE;
            runs_d  = runs_q;
            gcfg_d  = gcfg_q;
            idx_d   = idx_q;
            err_d   = err_q;
            code_d  = code_q;
        end
    end

    assign capture_req = (state_q == S_ARM) && !abort;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign err_code    = code_q;
    assign run_idx     = idx_q;

endmodule

// File: tb/tb_batch_capture_scheduler.sv
// Scoreboard bench for batch_capture_scheduler: a buffer model answers each
// capture_req, stimulus queues expected events, a monitor checks them.
module tb_batch_capture_scheduler;

    localparam int BATCH = 2048;
    localparam int MAXR  = 8;
    localparam int GW    = 16;
    localparam int TMO   = 4096;

    localparam int EV_REQ  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    localparam int M_GOOD   = 0;
    localparam int M_SHORT  = 1;
    localparam int M_SOPMID = 2;
    localparam int M_NOSOP  = 3;
    localparam int M_NOACK  = 4;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    cfg_runs = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic          capture_req;
    logic          capture_ack = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_sop = 1'b0;
    logic          src_eop = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [2:0]    run_idx;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  done_cyc = -100;
    int  mode = M_GOOD;
    int  runs_t = 1;
    int  gap_t = 0;
    int  resp_run = 0;
    int  beat_no = -1;
    bit  kill = 1'b0;
    ev_t exp_q[$];

    batch_capture_scheduler #(
        .BATCH_SIZE(BATCH),
        .MAX_RUNS  (MAXR),
        .GAP_WIDTH (GW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .cfg_runs   (cfg_runs),
        .cfg_gap    (cfg_gap),
        .capture_req(capture_req),
        .capture_ack(capture_ack),
        .src_valid  (src_valid),
        .src_sop    (src_sop),
        .src_eop    (src_eop),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .run_idx    (run_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(int k, int v, int at);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic sb_check(int kind, int val, string nm);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event val %0d at cycle %0d",
                     nm, val, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.val != val || (e.at >= 0 && e.at != cyc)) begin
            n_fail++;
            $display("FAIL %s: got kind %0d val %0d cycle %0d, required kind %0d val %0d cycle %0d",
                     nm, kind, val, cyc, e.kind, e.val, e.at);
        end
    endtask

    // monitor: pops one expectation per observed output event
    initial begin
        bit err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (capture_req) sb_check(EV_REQ, int'(run_idx), "req");
                if (done) begin
                    sb_check(EV_DONE, 0, "done");
                    done_cyc = cyc;
                end
                if (err && !err_prev) sb_check(EV_ERR, int'(err_code), "err");
            end
            err_prev = err;
        end
    end

    task automatic respond();
        int  len;
        int  r;
        bit  bad;
        r = resp_run;
        resp_run++;
        if (mode == M_NOACK) begin
            expect_ev(EV_ERR, 1, cyc + 1 + TMO);
            return;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (kill) return;
        end
        capture_ack = 1'b1;
        @(negedge clk);
        capture_ack = 1'b0;
        len = (mode == M_SHORT) ? BATCH - 1 : BATCH;
        for (int i = 0; i < len; i++) begin
            if (kill) break;
            beat_no   = i;
            bad       = (mode == M_NOSOP && i == 0) ||
                        (mode == M_SOPMID && i == 100);
            src_valid = 1'b1;
            src_sop   = (i == 0 && mode != M_NOSOP) ||
                        (mode == M_SOPMID && i == 100);
            src_eop   = (i == len - 1);
            if (bad) begin
                expect_ev(EV_ERR, 2, cyc + 1);
            end else if (i == len - 1) begin
                if (mode == M_SHORT) expect_ev(EV_ERR, 3, cyc + 1);
                else if (r == runs_t - 1) expect_ev(EV_DONE, 0, cyc + 1);
                else expect_ev(EV_REQ, r + 1,
                               cyc + 1 + ((gap_t == 0) ? 1 : gap_t));
            end
            @(negedge clk);
            if (bad) break;
        end
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
    endtask

    // buffer model
    initial begin
        forever begin
            @(negedge clk);
            if (capture_req && reset_n && !kill) respond();
        end
    end

    task automatic go(int runs, int gap, int md);
        @(negedge clk);
        mode     = md;
        runs_t   = runs;
        gap_t    = gap;
        resp_run = 0;
        beat_no  = -1;
        cfg_runs = 4'(runs);
        cfg_gap  = GW'(gap);
        start    = 1'b1;
        expect_ev(EV_REQ, 0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(int max, output int at);
        at = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (!busy) begin
                at = cyc;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_idle: busy %0d after %0d cycles, required 0",
                 busy, max);
    endtask

    initial begin
        #(70000 * 10);
        $display("FAIL watchdog: run did not finish by cycle %0d, required end", cyc);
        $fatal(1);
    end

    initial begin
        int at;
        int k;

        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", capture_req, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_idx", run_idx, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        go(3, 10, M_GOOD);
        check("t1_busy", busy, 1);
        wait_idle(20000, at);
        check("t1_busy_fall", at, done_cyc + 1);
        check("t1_err", err, 0);

        go(2, 0, M_GOOD);
        wait_idle(12000, at);
        check("t2_err", err, 0);

        go(1, 0, M_SHORT);
        wait_idle(5000, at);
        check("t3_err", err, 1);
        check("t3_code", err_code, 3);
        go(1, 0, M_GOOD);
        check("t3_err_clr", err, 0);
        check("t3_code_clr", err_code, 0);
        wait_idle(5000, at);
        check("t3_err_after", err, 0);

        go(1, 0, M_SOPMID);
        wait_idle(5000, at);
        check("t4_sopmid_code", err_code, 2);
        go(1, 0, M_NOSOP);
        wait_idle(5000, at);
        check("t4_nosop_err", err, 1);
        check("t4_nosop_code", err_code, 2);

        go(1, 0, M_NOACK);
        wait_idle(TMO + 200, at);
        check("t5_code", err_code, 1);

        go(3, 10, M_GOOD);
        k = 0;
        while (run_idx != 3'd1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_gap", k < 5000, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        check("t6_busy", busy, 0);
        check("t6_idx_hold", run_idx, 1);
        check("t6_err", err, 0);
        repeat (30) @(negedge clk);
        check("t6_still_idle", busy, 0);

        cfg_runs = 4'd1;
        mode     = M_NOACK;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t6_start_abort", busy, 0);

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("t6_req_forced", capture_req, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_arm_abort", busy, 0);

        cfg_runs = 4'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_runs0", busy, 0);
        cfg_runs = 4'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_runs9", busy, 0);

        go(2, 0, M_GOOD);
        k = 0;
        while (!(resp_run == 2 && beat_no >= 500) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check("t8_reach_drain", k < 8000, 1);
        check("t8_idx_pre", run_idx, 1);
        #2;
        reset_n = 1'b0;
        kill    = 1'b1;
        #1;
        check("t8_busy", busy, 0);
        check("t8_idx", run_idx, 0);
        check("t8_req", capture_req, 0);
        check("t8_done", done, 0);
        check("t8_err", err, 0);
        repeat (4) @(negedge clk);
        exp_q.delete();
        reset_n = 1'b1;
        kill    = 1'b0;
        repeat (4) @(negedge clk);
        check("t8_idle", busy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
